link_tx_arbiter: RTL

- Shares one serial link between up to N_CH on-board requesters.
- Each transfer is a 19-bit frame: a 3-bit address (the requester index) followed by 16-bit data, MSB first.
- Frames are framed with TX_LOAD/TX_STOP so the far-end 19-bit shift-register deserializer can present P_ADDR/P_DATA with a P_ENA strobe.
- Sits at board top between the channel sources and the link output pins. It is the transmit-side sequencer and scheduler for that deserializer.

---
 rtl/link_tx_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/link_tx_arbiter.sv
// link_tx_arbiter
//
// Transmit-side scheduler and serializer for a shared serial link. Up to N_CH
// requesters are arbitrated round-robin. Each grant sends a frame made of the
// requester index (ADDR_W bits) followed by its data word (DATA_W bits), MSB
// first. TX_LOAD marks frame bit 0 so the far-end deserializer can write, and
// TX_STOP marks every cycle that carries no frame bit. Consecutive frames are
// separated by GAP idle cycles.
//
// Ports:
//   CLK       in   link clock, all state on the rising edge
//   RST       in   asynchronous active-low reset
//   ENA       in   1 = new grants allowed; 0 = let the current frame finish, then stop
//   REQ       in   [N_CH] level request per channel, held until its ACK
//   DATA_IN   in   [N_CH*DATA_W] channel i data at [i*DATA_W +: DATA_W]
//   ACK       out  [N_CH] one-cycle pulse when a channel's data has been captured
//   TX_DATA   out  serial data, MSB first
//   TX_LOAD   out  high while TX_DATA carries frame bit 0
//   TX_STOP   out  high whenever no frame bit is on the line
//   BUSY      out  high from the grant edge until the gap after the frame ends
//   GRANT_ID  out  [ADDR_W] index of the last granted channel

module link_tx_arbiter #(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned GAP    = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ENA,
  input  logic [N_CH-1:0]        REQ,
  input  logic [N_CH*DATA_W-1:0] DATA_IN,
  output logic [N_CH-1:0]        ACK,
  output logic                   TX_DATA,
  output logic                   TX_LOAD,
  output logic                   TX_STOP,
  output logic                   BUSY,
  output logic [ADDR_W-1:0]      GRANT_ID
);

  localparam int unsigned FL = ADDR_W + DATA_W;
  localparam int unsigned CW = $clog2(FL);
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  // Frame bits still to be sent; the MSB goes straight onto TX_DATA at grant.
  logic [FL-2:0]     sr_q;
  // Index of the frame bit currently on TX_DATA.
  logic [CW-1:0]     cnt_q;
  logic [GW-1:0]     gap_q;

  // ---------------------------------------------------------------------------
  // Round-robin search: first set REQ bit at or above the pointer, wrapping.
  // ---------------------------------------------------------------------------
  logic              arb_hit;
  logic [ADDR_W-1:0] arb_idx;
  logic [DATA_W-1:0] arb_data;
  int unsigned       cand;

  always_comb begin
    arb_hit  = 1'b0;
    arb_idx  = '0;
    arb_data = '0;
    cand     = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= N_CH) begin
        cand = cand - N_CH;
      end
      if (!arb_hit && (((REQ >> cand) & N_CH'(1)) != '0)) begin
        arb_hit  = 1'b1;
        arb_idx  = ADDR_W'(cand);
        arb_data = DATA_IN[cand*DATA_W +: DATA_W];
      end
    end
  end

  logic [FL-1:0]     frame;
  logic [ADDR_W-1:0] ptr_nxt;
  logic              grant_ok;
  logic              arb_point;

  assign frame    = {arb_idx, arb_data};
  assign ptr_nxt  = (32'(arb_idx) + 32'd1 >= N_CH) ? '0 : ADDR_W'(32'(arb_idx) + 32'd1);
  assign grant_ok = ENA && arb_hit;

  // Edges at which a new grant may be made: idle, end of the gap, or the end
  // of bit 0 when frames run back to back.
  assign arb_point = (state_q == StIdle) ||
                     ((state_q == StShift) && (cnt_q == '0) && (GAP == 0)) ||
                     ((state_q == StGap) && (gap_q == '0));

  // ---------------------------------------------------------------------------
  // Sequencer with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      sr_q     <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      ACK      <= '0;
      TX_DATA  <= 1'b0;
      TX_LOAD  <= 1'b0;
      TX_STOP  <= 1'b1;
      BUSY     <= 1'b0;
      GRANT_ID <= '0;
    end else begin
      ACK <= '0;
      if (arb_point) begin
        if (grant_ok) begin
          state_q  <= StShift;
          sr_q     <= frame[FL-2:0];
          cnt_q    <= CW'(FL - 1);
          ptr_q    <= ptr_nxt;
          ACK      <= N_CH'(1) << arb_idx;
          GRANT_ID <= arb_idx;
          TX_DATA  <= frame[FL-1];
          TX_LOAD  <= 1'b0;
          TX_STOP  <= 1'b0;
          BUSY     <= 1'b1;
        end else begin
          state_q <= StIdle;
          TX_DATA <= 1'b0;
          TX_LOAD <= 1'b0;
          TX_STOP <= 1'b1;
          BUSY    <= 1'b0;
        end
      end else begin
        case (state_q)
          StShift: begin
            if (cnt_q != '0) begin
              TX_DATA <= sr_q[cnt_q - CW'(1)];
              // Raised on the edge that puts bit 0 on the line.
              TX_LOAD <= (cnt_q == CW'(1));
              cnt_q   <= cnt_q - CW'(1);
            end else begin
              // Only reached with GAP > 0; GAP == 0 re-arbitrates here instead.
              TX_DATA <= 1'b0;
              TX_LOAD <= 1'b0;
              TX_STOP <= 1'b1;
              gap_q   <= GW'(GAP - 1);
              state_q <= StGap;
            end
          end
          StGap: begin
            gap_q <= gap_q - GW'(1);
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
